// File: rtl/rsa_job_ctrl_if.sv
// Stream and core-side signal bundle for rsa_job_ctrl.
// The master modport is the job controller; the slave modport is the
// far side (bus/DMA stream source and sink plus the rsa4k core).
interface rsa_job_ctrl_if #(
  parameter int unsigned WIDTH = 4096,
  parameter int unsigned WORD  = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WORD-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WORD-1:0]  out_data;
  logic             out_last;
  logic             core_reset;
  logic             core_go;
  logic [WIDTH-1:0] core_message;
  logic [WIDTH-1:0] core_exponent;
  logic [WIDTH-1:0] core_modulus;
  logic [WIDTH-1:0] core_cypher;
  logic             core_done;

  modport master (
    input  in_valid, in_data, out_ready, core_cypher, core_done,
    output in_ready, out_valid, out_data, out_last,
           core_reset, core_go, core_message, core_exponent, core_modulus
  );

  modport slave (
    output in_valid, in_data, out_ready, core_cypher, core_done,
    input  in_ready, out_valid, out_data, out_last,
           core_reset, core_go, core_message, core_exponent, core_modulus
  );
endinterface

// File: rtl/rsa_job_ctrl.sv
// Job controller for the rsa4k modular-exponentiation core.
// Collects message, exponent and modulus as a narrow word stream,
// sequences the core through reset/go/done and streams the cypher back.
module rsa_job_ctrl #(
  parameter int unsigned WIDTH   = 4096,
  parameter int unsigned WORD    = 32,
  parameter logic [31:0] TIMEOUT = 32'd50000000
) (
  input  logic          clk,
  input  logic          reset,
  rsa_job_ctrl_if.master bus,
  output logic          busy,
  output logic          err
);

  localparam int unsigned   NW       = WIDTH / WORD;
  localparam int unsigned   IW       = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CRST,
    S_GO,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  // The input word counter is held as (operand select, word index) so no
  // division by NW is needed; together they walk 0..3*NW-1.
  logic [1:0]       opsel;
  logic [IW-1:0]    widx;
  logic [IW-1:0]    k;
  logic [31:0]      timer;
  logic [WIDTH-1:0] msg_q, exp_q, mod_q, res_q;
  logic             err_q;

  logic             accept, xfer, timeout_hit, last_word;
  logic             in_rdy, crst, go, oval, olast;
  logic [WORD-1:0]  odata;

  assign last_word = (opsel == 2'd2) && (widx == LAST_IDX);

  // Next-state decode and per-state handshake/control outputs.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    xfer        = 1'b0;
    timeout_hit = 1'b0;
    in_rdy      = 1'b0;
    crst        = 1'b0;
    go          = 1'b0;
    oval        = 1'b0;
    olast       = 1'b0;
    busy        = 1'b1;
    case (state)
      S_LOAD: begin
        in_rdy = 1'b1;
        crst   = 1'b1;
        busy   = 1'b0;
        accept = bus.in_valid;
        if (accept && last_word) state_nxt = S_CRST;
      end
      S_CRST: begin
        crst      = 1'b1;
        state_nxt = S_GO;
      end
      S_GO: begin
        go        = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        go = 1'b1;
        if (bus.core_done) begin
          state_nxt = S_DRAIN;
        end else if ((TIMEOUT != 32'd0) && (timer == TIMEOUT - 32'd1)) begin
          timeout_hit = 1'b1;
          state_nxt   = S_LOAD;
        end
      end
      S_DRAIN: begin
        oval  = 1'b1;
        olast = (k == LAST_IDX);
        xfer  = bus.out_ready;
        if (xfer && (k == LAST_IDX)) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Result word selection; zero outside DRAIN so idle output is quiet.
  always_comb begin
    odata = '0;
    if (state == S_DRAIN) begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (k == IW'(i)) odata = res_q[i*WORD +: WORD];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  // Operand capture, wait timer, result latch, drain index and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opsel <= '0;
      widx  <= '0;
      k     <= '0;
      timer <= '0;
      msg_q <= '0;
      exp_q <= '0;
      mod_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= 1'b0;
        for (int unsigned i = 0; i < NW; i++) begin
          if (widx == IW'(i)) begin
            case (opsel)
              2'd0:    msg_q[i*WORD +: WORD] <= bus.in_data;
              2'd1:    exp_q[i*WORD +: WORD] <= bus.in_data;
              default: mod_q[i*WORD +: WORD] <= bus.in_data;
            endcase
          end
        end
        if (widx == LAST_IDX) begin
          widx  <= '0;
          opsel <= (opsel == 2'd2) ? 2'd0 : opsel + 2'd1;
        end else begin
          widx <= widx + 1'b1;
        end
      end
      if (state == S_GO)        timer <= '0;
      else if (state == S_WAIT) timer <= timer + 32'd1;
      if ((state == S_WAIT) && bus.core_done) res_q <= bus.core_cypher;
      if (timeout_hit) err_q <= 1'b1;
      if (xfer) k <= (k == LAST_IDX) ? '0 : k + 1'b1;
    end
  end

  assign bus.in_ready      = in_rdy;
  assign bus.core_reset    = crst;
  assign bus.core_go       = go;
  assign bus.out_valid     = oval;
  assign bus.out_last      = olast;
  assign bus.out_data      = odata;
  assign bus.core_message  = msg_q;
  assign bus.core_exponent = exp_q;
  assign bus.core_modulus  = mod_q;
  assign err               = err_q;

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Directed bench for rsa_job_ctrl with a 20-cycle behavioural rsa4k model.
module tb_rsa_job_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic busy, err;

  rsa_job_ctrl_if #(.WIDTH(64), .WORD(32)) bus ();

  rsa_job_ctrl #(.WIDTH(64), .WORD(32), .TIMEOUT(32'd1000)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic tmo = 1'b0;
  logic hang = 1'b0;

  // rsa4k model: captures operands on go, answers 20 cycles later unless hung.
  logic [63:0] rx_m, rx_e, rx_n;
  logic go_d;
  int mcnt;

  function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
    logic [63:0] r, x, ee;
    r = 64'd1; x = b % m; ee = e;
    while (ee != 64'd0) begin
      if (ee[0]) r = (r * x) % m;
      x = (x * x) % m;
      ee = ee >> 1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.core_done   <= 1'b0;
      bus.core_cypher <= '0;
      mcnt <= 0; go_d <= 1'b0;
      rx_m <= '0; rx_e <= '0; rx_n <= '0;
    end else begin
      go_d <= bus.core_go;
      if (bus.core_reset) begin
        bus.core_done <= 1'b0;
        mcnt <= 0;
      end else if (bus.core_go && !bus.core_done) begin
        if (!go_d) begin
          rx_m <= bus.core_message; rx_e <= bus.core_exponent; rx_n <= bus.core_modulus;
        end
        if (!hang) begin
          if (mcnt == 19) begin
            bus.core_done   <= 1'b1;
            bus.core_cypher <= modexp(bus.core_message, bus.core_exponent, bus.core_modulus);
          end
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  // Monitors: busy must be the complement of in_ready; count core_reset cycles.
  int busy_bad = 0;
  int rst_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (busy !== ~bus.in_ready) busy_bad++;
      if (bus.core_reset) rst_cnt++;
    end
  end

  // Receive results
  logic [31:0] rw [2];
  logic        rl [2];
  int rn, runst, rextra;

  task automatic send_word(input logic [31:0] w);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = w;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo = 1'b1;
  endtask

  task automatic send_job(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n, input bit gappy);
    logic [31:0] ws [6];
    ws[0] = m[31:0]; ws[1] = m[63:32];
    ws[2] = e[31:0]; ws[3] = e[63:32];
    ws[4] = n[31:0]; ws[5] = n[63:32];
    for (int i = 0; i < 6; i++) begin
      if (gappy) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk); bus.in_valid = 1'b0; bus.in_data = $urandom;
        end
      end
      send_word(ws[i]);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.core_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) tmo = 1'b1;
  endtask

  task automatic recv(input int duty);
    logic [31:0] pd;
    logic pl, pstall;
    rn = 0; runst = 0; rextra = 0; pstall = 1'b0; pd = '0; pl = 1'b0;
    for (int c = 0; c < 400 && rn < 2; c++) begin
      @(negedge clk);
      if (pstall && bus.out_valid) begin
        if (bus.out_data !== pd || bus.out_last !== pl) runst++;
      end
      bus.out_ready = ($urandom_range(0, 99) < duty);
      if (bus.out_valid && bus.out_ready) begin
        rw[rn] = bus.out_data; rl[rn] = bus.out_last; rn++;
      end
      pstall = bus.out_valid && !bus.out_ready;
      pd = bus.out_data; pl = bus.out_last;
    end
    if (rn < 2) tmo = 1'b1;
    repeat (8) begin
      @(negedge clk); bus.out_ready = 1'b1;
      if (bus.out_valid) rextra++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got %0b want 1", bus.core_reset); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out got v=%0b l=%0b want 0 0", bus.out_valid, bus.out_last); end
    checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data got %0h want 0", bus.out_data); end
    checks++; if (bus.core_go !== 1'b0 || bus.core_reset !== 1'b1) begin errors++; $display("FAIL rst_core got go=%0b rst=%0b want 0 1", bus.core_go, bus.core_reset); end
    checks++; if (bus.core_message !== 64'd0 || bus.core_exponent !== 64'd0 || bus.core_modulus !== 64'd0) begin errors++; $display("FAIL rst_operands got %0h %0h %0h want 0", bus.core_message, bus.core_exponent, bus.core_modulus); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_flags got busy=%0b err=%0b want 0 0", busy, err); end
  endtask

  task automatic test_basic();
    send_job(64'd8, 64'd13, 64'd77, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0;
    checks++; if (bus.core_reset !== 1'b1 || bus.core_go !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_crst got rst=%0b go=%0b rdy=%0b busy=%0b want 1 0 0 1", bus.core_reset, bus.core_go, bus.in_ready, busy); end
    @(negedge clk);
    checks++; if (bus.core_go !== 1'b1 || bus.core_reset !== 1'b0) begin errors++; $display("FAIL basic_go got go=%0b rst=%0b want 1 0", bus.core_go, bus.core_reset); end
    checks++; if (bus.core_message !== 64'd8 || bus.core_exponent !== 64'd13 || bus.core_modulus !== 64'd77) begin errors++; $display("FAIL basic_operands got %0d %0d %0d want 8 13 77", bus.core_message, bus.core_exponent, bus.core_modulus); end
    wait_done();
    checks++; if (bus.core_go !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_wait got go=%0b v=%0b want 1 0", bus.core_go, bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.core_go !== 1'b0) begin errors++; $display("FAIL basic_drain_start got v=%0b go=%0b want 1 0", bus.out_valid, bus.core_go); end
    recv(100);
    checks++; if (rn !== 2 || rw[0] !== 32'd50 || rw[1] !== 32'd0) begin errors++; $display("FAIL basic_result got n=%0d %0d %0d want 2 50 0", rn, rw[0], rw[1]); end
    checks++; if (rl[0] !== 1'b0 || rl[1] !== 1'b1) begin errors++; $display("FAIL basic_last got %0b%0b want 01", rl[0], rl[1]); end
    checks++; if (busy !== 1'b0 || bus.core_reset !== 1'b1 || bus.in_ready !== 1'b1 || err !== 1'b0 || rextra !== 0) begin errors++; $display("FAIL basic_end got busy=%0b rst=%0b rdy=%0b err=%0b extra=%0d want 0 1 1 0 0", busy, bus.core_reset, bus.in_ready, err, rextra); end
  endtask

  task automatic test_back_to_back();
    int r0;
    send_job(64'd8, 64'd13, 64'd77, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0;
    wait_done();
    r0 = rst_cnt;
    fork
      recv(100);
      send_job(64'd50, 64'd37, 64'd77, 1'b0);
    join
    @(negedge clk); bus.in_valid = 1'b0;
    checks++; if (rw[0] !== 32'd50 || rw[1] !== 32'd0 || rextra !== 0) begin errors++; $display("FAIL b2b_first got %0d %0d extra=%0d want 50 0 0", rw[0], rw[1], rextra); end
    checks++; if (rst_cnt - r0 < 6) begin errors++; $display("FAIL b2b_core_reset got %0d cycles want >=6", rst_cnt - r0); end
    wait_done();
    recv(100);
    checks++; if (rn !== 2 || rw[0] !== 32'd8 || rw[1] !== 32'd0) begin errors++; $display("FAIL b2b_second got n=%0d %0d %0d want 2 8 0", rn, rw[0], rw[1]); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL b2b_busy got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_stall();
    send_job(64'd50, 64'd37, 64'd77, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0;
    wait_done();
    recv(30);
    checks++; if (rn !== 2 || rw[0] !== 32'd8 || rw[1] !== 32'd0) begin errors++; $display("FAIL stall_data got n=%0d %0d %0d want 2 8 0", rn, rw[0], rw[1]); end
    checks++; if (rl[0] !== 1'b0 || rl[1] !== 1'b1) begin errors++; $display("FAIL stall_last got %0b%0b want 01", rl[0], rl[1]); end
    checks++; if (runst !== 0 || rextra !== 0) begin errors++; $display("FAIL stall_stable got unstable=%0d extra=%0d want 0 0", runst, rextra); end
  endtask

  task automatic test_timeout();
    int go_n, ov_n;
    hang = 1'b1;
    send_job(64'd8, 64'd13, 64'd77, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0;
    go_n = 0; ov_n = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (bus.core_go) go_n++;
      if (bus.out_valid) ov_n++;
      if (err) break;
    end
    checks++; if (err !== 1'b1 || go_n !== 1001) begin errors++; $display("FAIL tmo_err got err=%0b go_cycles=%0d want 1 1001", err, go_n); end
    checks++; if (bus.core_go !== 1'b0 || bus.core_reset !== 1'b1 || bus.in_ready !== 1'b1 || ov_n !== 0) begin errors++; $display("FAIL tmo_state got go=%0b rst=%0b rdy=%0b ov=%0d want 0 1 1 0", bus.core_go, bus.core_reset, bus.in_ready, ov_n); end
    hang = 1'b0;
    send_word(32'd8);
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_clear got %0b want 0", err); end
    bus.in_valid = 1'b0;
    send_word(32'd0); send_word(32'd13); send_word(32'd0); send_word(32'd77); send_word(32'd0);
    @(negedge clk); bus.in_valid = 1'b0;
    wait_done();
    recv(100);
    checks++; if (rn !== 2 || rw[0] !== 32'd50 || rw[1] !== 32'd0) begin errors++; $display("FAIL tmo_recover got n=%0d %0d %0d want 2 50 0", rn, rw[0], rw[1]); end
  endtask

  task automatic test_reset_mid();
    send_word(32'd8); send_word(32'd0); send_word(32'd13);
    @(negedge clk); bus.in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.core_reset !== 1'b1 || bus.core_go !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ctl got rdy=%0b v=%0b rst=%0b go=%0b busy=%0b want 1 0 1 0 0", bus.in_ready, bus.out_valid, bus.core_reset, bus.core_go, busy); end
    checks++; if (bus.core_message !== 64'd0 || bus.core_exponent !== 64'd0) begin errors++; $display("FAIL midrst_ops got %0h %0h want 0 0", bus.core_message, bus.core_exponent); end
    reset = 1'b0;
    send_job(64'd8, 64'd13, 64'd77, 1'b0);
    @(negedge clk); bus.in_valid = 1'b0;
    wait_done();
    recv(100);
    checks++; if (rn !== 2 || rw[0] !== 32'd50 || rw[1] !== 32'd0) begin errors++; $display("FAIL midrst_job got n=%0d %0d %0d want 2 50 0", rn, rw[0], rw[1]); end
  endtask

  task automatic test_noise();
    send_job(64'd8, 64'd13, 64'd77, 1'b1);
    @(negedge clk); bus.in_valid = 1'b0;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_data = 32'hffff_ffff;
    wait_done();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL noise_drain got v=%0b rdy=%0b want 1 0", bus.out_valid, bus.in_ready); end
    bus.in_valid = 1'b0;
    checks++; if (rx_m !== 64'd8 || rx_e !== 64'd13 || rx_n !== 64'd77) begin errors++; $display("FAIL noise_rx got %0h %0h %0h want 8 d 4d", rx_m, rx_e, rx_n); end
    checks++; if (bus.core_message !== 64'd8 || bus.core_exponent !== 64'd13 || bus.core_modulus !== 64'd77) begin errors++; $display("FAIL noise_ops got %0h %0h %0h want 8 d 4d", bus.core_message, bus.core_exponent, bus.core_modulus); end
    recv(100);
    checks++; if (rn !== 2 || rw[0] !== 32'd50 || rw[1] !== 32'd0) begin errors++; $display("FAIL noise_result got n=%0d %0d %0d want 2 50 0", rn, rw[0], rw[1]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_noise();
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL handshake_bound got expired=%0b want 0", tmo); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got time=%0t want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
